// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between a fetch port
// (read-only) and a data port (read/write). After reset it clears the whole
// RAM, then arbitrates one access per cycle with 1-bit round-robin priority.
//
// Handshake: a requester holds req and its address/data stable until it sees
// gnt high in the same cycle. Grants are combinational, so the accepted access
// is presented to the RAM in that cycle. A granted read returns rvalid/rdata
// exactly one cycle later. Writes finish at the grant and never return rvalid.
module ram_arbiter #(
  parameter int D_BITS = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [D_BITS-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [D_BITS-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [D_BITS-1:0] d_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [D_BITS-1:0] ram_din,
  output logic              ram_we,
  input  logic [D_BITS-1:0] ram_dout,
  output logic              init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [D_BITS-1:0] din_q;
  logic              prio_q;
  logic              i_tag_q;
  logic              d_tag_q;
  logic              init_done_q;
  logic              clr_last;

  assign clr_last = (clr_cnt_q == {ADDR_W{1'b1}});

  // Next state, arbitration and RAM drive; idle RUN cycles replay the last
  // address/data so the RAM bus only changes when an access is made.
  always_comb begin
    state_d  = state_q;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_din  = din_q;
    case (state_q)
      ST_INIT: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
        ram_din  = '0;
        if (clr_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_req && (!d_req || !prio_q)) begin
          i_gnt    = 1'b1;
          ram_addr = i_addr;
        end else if (d_req) begin
          d_gnt    = 1'b1;
          ram_addr = d_addr;
          ram_we   = d_we;
          ram_din  = d_wdata;
        end
      end
      default: state_d = ST_INIT;
    endcase
    // Reset holds the RAM quiet; state/counter are already cleared, which
    // forces grants off and the address/data to zero.
    if (!rst_n) ram_we = 1'b0;
  end

  // State register, clear counter, priority, read tags and held RAM bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      prio_q      <= 1'b0;
      i_tag_q     <= 1'b0;
      d_tag_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= ram_addr;
      din_q   <= ram_din;
      i_tag_q <= i_gnt;
      d_tag_q <= d_gnt & ~d_we;
      if (state_q == ST_INIT) begin
        clr_cnt_q <= clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (clr_last) init_done_q <= 1'b1;
      end
      if (i_gnt)      prio_q <= 1'b1;
      else if (d_gnt) prio_q <= 1'b0;
    end
  end

  assign i_rvalid  = i_tag_q;
  assign d_rvalid  = d_tag_q;
  assign i_rdata   = ram_dout;
  assign d_rdata   = ram_dout;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural
// synchronous RAM (1-cycle read latency, read-before-write).
// Inputs are driven just after the falling edge and outputs sampled 1ns later.
module tb_ram_arbiter;

  localparam int D_BITS = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [D_BITS-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [D_BITS-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [D_BITS-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [D_BITS-1:0] ram_din;
  logic              ram_we;
  logic [D_BITS-1:0] ram_dout;
  logic              init_done;

  int checks;
  int failures;

  logic [D_BITS-1:0] mem [DEPTH];

  ram_arbiter #(.D_BITS(D_BITS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read returns the pre-write word
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Walk n clear cycles; caller is already 1ns past the falling edge of cycle 0.
  task automatic init_sweep(input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      check("init_we",   ram_we, 1);
      check("init_addr", ram_addr, k);
      check("init_din",  ram_din, 0);
      check("init_gnt",  {i_gnt, d_gnt}, 0);
      check("init_done_low", init_done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // reset values
    #3;
    check("rst_we",     ram_we, 0);
    check("rst_addr",   ram_addr, 0);
    check("rst_din",    ram_din, 0);
    check("rst_gnt",    {i_gnt, d_gnt}, 0);
    check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    check("rst_done",   init_done, 0);

    // clear sequence with a fetch request held throughout
    @(negedge clk);
    rst_n = 1'b1; i_req = 1'b1; i_addr = 5;
    #1;
    init_sweep(32);

    // cycle 32: held request granted at once
    @(negedge clk); #1;
    check("done_high",   init_done, 1);
    check("held_i_gnt",  i_gnt, 1);
    check("held_d_gnt",  d_gnt, 0);
    check("held_addr",   ram_addr, 5);
    check("held_we",     ram_we, 0);
    @(negedge clk); i_req = 1'b0; #1;
    check("held_rvalid", i_rvalid, 1);
    check("held_rdata",  i_rdata, 0);
    check("held_d_rv",   d_rvalid, 0);
    check("idle_we",     ram_we, 0);
    check("idle_addr",   ram_addr, 5);

    // write 7 then fetch 7
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 7; d_wdata = 32'hDEADBEEF;
    #1;
    check("wr7_d_gnt", d_gnt, 1);
    check("wr7_i_gnt", i_gnt, 0);
    check("wr7_we",    ram_we, 1);
    check("wr7_addr",  ram_addr, 7);
    check("wr7_din",   ram_din, 32'hDEADBEEF);
    @(negedge clk);
    d_req = 1'b0; i_req = 1'b1; i_addr = 7;
    #1;
    check("rd7_i_gnt", i_gnt, 1);
    check("rd7_we",    ram_we, 0);
    check("rd7_addr",  ram_addr, 7);
    check("wr7_no_rv", d_rvalid, 0);
    @(negedge clk); i_req = 1'b0; #1;
    check("rd7_rvalid", i_rvalid, 1);
    check("rd7_rdata",  i_rdata, 32'hDEADBEEF);
    check("rd7_d_rv",   d_rvalid, 0);

    // writes 1..3 back to back
    for (int a = 1; a <= 3; a++) begin
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = a[ADDR_W-1:0]; d_wdata = 32'h11 * a;
      #1;
      check("wr_gnt",  d_gnt, 1);
      check("wr_addr", ram_addr, a);
      check("wr_din",  ram_din, 32'h11 * a);
      check("wr_no_rv", {i_rvalid, d_rvalid}, 0);
    end

    // fetch reads 1..3 back to back
    for (int a = 1; a <= 3; a++) begin
      @(negedge clk);
      d_req = 1'b0; i_req = 1'b1; i_addr = a[ADDR_W-1:0];
      #1;
      check("seq_gnt",  i_gnt, 1);
      check("seq_addr", ram_addr, a);
      if (a > 1) begin
        check("seq_rvalid", i_rvalid, 1);
        check("seq_rdata",  i_rdata, 32'h11 * (a - 1));
      end
    end
    @(negedge clk); i_req = 1'b0; #1;
    check("seq_rvalid3", i_rvalid, 1);
    check("seq_rdata3",  i_rdata, 32'h33);
    @(negedge clk); #1;
    check("seq_rv_end", i_rvalid, 0);

    // data read of 2 returns prio to fetch
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 2;
    #1;
    check("drd_gnt", d_gnt, 1);
    check("drd_we",  ram_we, 0);
    @(negedge clk); d_req = 1'b0; #1;
    check("drd_rvalid", d_rvalid, 1);
    check("drd_rdata",  d_rdata, 32'h22);
    check("drd_i_rv",   i_rvalid, 0);

    // both requesting for 4 cycles: I, D, I, D
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      i_req = 1'b1; i_addr = 1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 3;
      #1;
      check("rr_i_gnt", i_gnt, (c % 2 == 0));
      check("rr_d_gnt", d_gnt, (c % 2 == 1));
      check("rr_addr",  ram_addr, (c % 2 == 0) ? 1 : 3);
      if (c > 0) begin
        check("rr_i_rv", i_rvalid, (c % 2 == 1));
        check("rr_d_rv", d_rvalid, (c % 2 == 0));
        check("rr_data", (c % 2 == 1) ? i_rdata : d_rdata, (c % 2 == 1) ? 32'h11 : 32'h33);
      end
    end
    @(negedge clk); i_req = 1'b0; d_req = 1'b0; #1;
    check("rr_last_d_rv", d_rvalid, 1);
    check("rr_last_data", d_rdata, 32'h33);
    check("rr_last_i_rv", i_rvalid, 0);

    // read granted, then reset before its response cycle
    @(negedge clk);
    i_req = 1'b1; i_addr = 3;
    #1;
    check("abort_gnt", i_gnt, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_gnt_off", i_gnt, 0);
    check("abort_we",      ram_we, 0);
    check("abort_addr",    ram_addr, 0);
    i_req = 1'b0;
    @(posedge clk); #1;
    check("abort_rv_a", {i_rvalid, d_rvalid}, 0);
    @(negedge clk); #1;
    check("abort_rv_b", {i_rvalid, d_rvalid}, 0);

    // clear interrupted at cycle 10 restarts from address 0
    @(negedge clk); rst_n = 1'b1; #1;
    init_sweep(11);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_we",   ram_we, 0);
    check("mid_rst_addr", ram_addr, 0);
    check("mid_rst_din",  ram_din, 0);
    check("mid_rst_done", init_done, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    init_sweep(32);
    @(negedge clk); #1;
    check("redone_high", init_done, 1);
    check("redone_we",   ram_we, 0);

    // priority was cleared by reset: conflict goes to fetch
    @(negedge clk);
    i_req = 1'b1; i_addr = 7;
    d_req = 1'b1; d_we = 1'b0; d_addr = 1;
    #1;
    check("prio_rst_i", i_gnt, 1);
    check("prio_rst_d", d_gnt, 0);
    @(negedge clk); i_req = 1'b0; d_req = 1'b0; #1;
    check("cleared_rdata", i_rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter D_BITS, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; the RAM depth is 2^ADDR_W words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port i_req, input, 1, fetch-port read request; held with i_addr until granted.
REQ-006 SHALL have port i_addr, input, ADDR_W, fetch read address.
REQ-007 SHALL have port i_gnt, output, 1, fetch request accepted this cycle.
REQ-008 SHALL have port i_rvalid, output, 1, fetch read data valid.
REQ-009 SHALL have port i_rdata, output, D_BITS, fetch read data.
REQ-010 SHALL have port d_req, input, 1, data-port request; held with d_we, d_addr and d_wdata until granted.
REQ-011 SHALL have ports d_we (input, 1, 1 = write, 0 = read), d_addr (input, ADDR_W) and d_wdata (input, D_BITS).
REQ-012 SHALL have ports d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, D_BITS), with the same meanings as the fetch-port signals.
REQ-013 SHALL have RAM-side ports: ram_addr (output, ADDR_W), ram_din (output, D_BITS), ram_we (output, 1) and ram_dout (input, D_BITS).
REQ-014 ram_dout SHALL be treated as registered, with 1-cycle read latency; a read during a write to the same address returns the old word.
REQ-015 SHALL have port init_done, output, 1, high once the clear sequence has completed.

Function
REQ-016 SHALL implement a two-state FSM, INIT and RUN; reset enters INIT.
REQ-017 In INIT, each cycle SHALL drive ram_we=1, ram_addr=clr_cnt and ram_din=0, then increment clr_cnt (ADDR_W bits, reset 0).
REQ-018 When clr_cnt reaches 2^ADDR_W-1 and that word is written, the FSM SHALL move to RUN and set init_done=1; INIT lasts exactly 2^ADDR_W cycles.
REQ-019 In INIT, i_gnt and d_gnt SHALL be 0; held requests wait and are not dropped.
REQ-020 In RUN, grants SHALL be combinational in the request cycle: at most one of i_gnt/d_gnt per cycle, and a grant only to an asserted request.
REQ-021 With a single requester, that requester SHALL be granted in the same cycle.
REQ-022 A conflict (both requests high) SHALL be resolved by the 1-bit round-robin register prio (reset 0): prio=0 grants the fetch port, prio=1 grants the data port.
REQ-023 After a fetch grant prio SHALL become 1; after a data grant prio SHALL become 0; with no grant prio holds.
REQ-024 On a grant, ram_addr SHALL equal the winner's address; ram_we=d_we and ram_din=d_wdata for a data grant; ram_we=0 for a fetch grant.
REQ-025 With no grant in RUN, ram_we SHALL be 0 and ram_addr/ram_din SHALL hold their last driven values (don't-care to the RAM).
REQ-026 A registered tag SHALL record the read grant; exactly one cycle after a read grant, the matching rvalid SHALL pulse for 1 cycle with its rdata equal to ram_dout.
REQ-027 Writes SHALL produce no rvalid; a write completes at its grant.
REQ-028 Throughput SHALL be 1 access/cycle: back-to-back grants with overlapping responses are legal.
REQ-029 i_rdata/d_rdata SHALL be don't-care while the matching rvalid is 0.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) force FSM=INIT, clr_cnt=0, prio=0, rvalid tag cleared and init_done=0.
REQ-031 While rst_n is low, the outputs SHALL be: i_gnt=d_gnt=0, i_rvalid=d_rvalid=0, ram_we=0, ram_addr=0, ram_din=0.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL abort any in-flight read with no rvalid issued; after release the full clear sequence restarts from address 0.

Verification
REQ-033 Reset release, ADDR_W=5 -> ram_we=1 for 32 cycles at addresses 0..31 with din=0; init_done=1 from cycle 32; no grants during those cycles.
REQ-034 In RUN, d write addr 7 value 0xDEADBEEF, then a fetch read of addr 7 in the next cycle -> d_gnt, then i_gnt; i_rvalid one cycle later with i_rdata=0xDEADBEEF.
REQ-035 Both requests held high for 4 cycles from prio=0 -> grants in order I, D, I, D; each read's rvalid goes to the correct port 1 cycle after its grant.
REQ-036 Fetch reads of addresses 1,2,3 on consecutive cycles -> i_gnt high 3 cycles; i_rvalid high 3 consecutive cycles with data in order 1,2,3.
REQ-037 rst_n pulsed low at INIT cycle 10 -> outputs go to reset values immediately; after release the clear restarts at address 0 and init_done rises 32 cycles later.
REQ-038 Read granted then rst_n asserted before the response cycle -> no rvalid is generated.
